bootram_ctrl: RTL

Controller for the 32-bit boot RAM, built from four 2Kx8 single-port BRAM byte lanes with a shared 11-bit word address. It shares the RAM between the CPU native memory port (valid/ready) and a boot-loader write/read port. It arbitrates round-robin and sequences CE/WRE per lane. It also returns registered read data and a one-cycle ready pulse to the granted requester.

---
 rtl/bootram_pkg.sv | 18 +
 rtl/bootram_ctrl_rr_arb2.sv | 37 +++
 rtl/bootram_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM controller.
package bootram_pkg;

  localparam int BOOTRAM_AW    = 11;
  localparam int BOOTRAM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_t;

endpackage

// File: rtl/bootram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that did not
// win last time is granted; last_grant only moves on the update strobe.
module rr_arb2
  import bootram_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic req_cpu,
  input  logic req_ld,
  input  logic update,
  output gnt_t gnt,
  output logic any_req
);

  gnt_t last_grant;

  // Grant selection: single requester wins outright, ties alternate.
  always_comb begin
    any_req = req_cpu | req_ld;
    gnt     = GNT_CPU;
    if (req_ld && !req_cpu) begin
      gnt = GNT_LD;
    end else if (req_cpu && req_ld) begin
      gnt = (last_grant == GNT_CPU) ? GNT_LD : GNT_CPU;
    end
  end

  // Last-grant history; reset to loader so the CPU wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= GNT_LD;
    end else if (update && any_req) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: shares four 2Kx8 byte-lane BRAMs between the CPU
// memory port and the boot-loader port. One access every three cycles.
// Optional write protection of CPU writes: define BOOTRAM_WP_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate; RAM strobed combinationally for the granted port
// ACCESS | RAM idle, addressed word on ram_dout, captured on reads
// RESP   | granted ready high for this single cycle
module bootram_ctrl
  import bootram_pkg::*;
#(
  parameter int AW = BOOTRAM_AW
)(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cpu_valid,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [BOOTRAM_LANES-1:0] cpu_wstrb,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  input  logic [31:0]              ld_wdata,
  input  logic [BOOTRAM_LANES-1:0] ld_wstrb,
  output logic                     ld_ready,
  output logic [31:0]              ld_rdata,
  output logic                     ram_ce,
  output logic                     ram_oce,
  output logic [BOOTRAM_LANES-1:0] ram_wre,
  output logic [AW-1:0]            ram_ad,
  output logic [31:0]              ram_din,
  input  logic [31:0]              ram_dout
`ifdef BOOTRAM_WP_EN
  ,
  input  logic                     wp,
  output logic                     wp_err
`endif
);

  state_t state_q, state_d;
  gnt_t   gnt, gnt_q;
  logic   any_req;
  logic   is_write_q;
  logic   cpu_wr_blocked;
  logic   start;

  // Address bits outside the word window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0],
                              ld_addr[31:AW+2], ld_addr[1:0]};

`ifdef BOOTRAM_WP_EN
  assign cpu_wr_blocked = wp;
`else
  assign cpu_wr_blocked = 1'b0;
`endif

  assign start = (state_q == IDLE) && any_req;

  rr_arb2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req_cpu (cpu_valid),
    .req_ld  (ld_valid),
    .update  (start),
    .gnt     (gnt),
    .any_req (any_req)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed three-cycle walk once a request is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM strobes: only in the accepting IDLE cycle, and never while reset
  // is held so an in-flight request cannot write during reset.
  always_comb begin
    ram_ce  = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    ram_wre = '0;
    if (resetn && start) begin
      ram_ce = 1'b1;
      if (gnt == GNT_CPU) begin
        ram_ad  = cpu_addr[AW+1:2];
        ram_din = cpu_wdata;
        ram_wre = cpu_wr_blocked ? '0 : cpu_wstrb;
      end else begin
        ram_ad  = ld_addr[AW+1:2];
        ram_din = ld_wdata;
        ram_wre = ld_wstrb;
      end
    end
  end

  assign ram_oce = ram_ce;

  // Transaction bookkeeping, read-data capture and one-cycle ready pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_q      <= GNT_CPU;
      is_write_q <= 1'b0;
      cpu_ready  <= 1'b0;
      ld_ready   <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      ld_ready  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q      <= gnt;
            is_write_q <= (gnt == GNT_CPU) ? (|cpu_wstrb) : (|ld_wstrb);
          end
        end
        ACCESS: begin
          if (gnt_q == GNT_CPU) begin
            cpu_ready <= 1'b1;
            if (!is_write_q) cpu_rdata <= ram_dout;
          end else begin
            ld_ready <= 1'b1;
            if (!is_write_q) ld_rdata <= ram_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BOOTRAM_WP_EN
  // Sticky flag for CPU writes suppressed by write protection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_err <= 1'b0;
    end else if (start && gnt == GNT_CPU && (|cpu_wstrb) && wp) begin
      wp_err <= 1'b1;
    end
  end
`endif

endmodule
